// File: rtl/pea_output_reader_if.sv
// pea_output_reader_if: 16-bit host stream carrying one result/status record as four tagged words.
interface pea_output_reader_if #(parameter int width = 16);
  logic [width-1:0] out_data;
  logic [1:0]       out_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  modport master (output out_data, out_tag, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_tag, out_valid, out_last, output out_ready);
endinterface

// File: rtl/pea_output_reader.sv
// pea_output_reader: pops result/status FIFO pairs and serialises each pair as four host words.
module pea_output_reader #(
  parameter int buffer_size_out = 32,
  parameter int width           = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(buffer_size_out)-1:0] result_pop,
  input  logic [$clog2(buffer_size_out)-1:0] status_pop,
  input  logic [2*width-1:0]                 result_data,
  input  logic [2*width-1:0]                 status_data,
  output logic                               rd_en_result,
  output logic                               rd_en_status,
  pea_output_reader_if.master                host,
  output logic [15:0]                        records_sent,
  output logic                               desync
);
  typedef enum logic [1:0] {IDLE, POP, CAPTURE, SEND} state_t;
  state_t             state_q;
  logic [1:0]         idx_q;
  logic [2*width-1:0] res_q, sta_q;
  logic [15:0]        records_q;
  logic               desync_q, mm_q, rd_en_q, valid_q;
  logic               mismatch;
  logic [2*width-1:0] word;
  logic [width-1:0]   half;
  assign mismatch = result_pop != status_pop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      res_q     <= '0;
      sta_q     <= '0;
      records_q <= '0;
      desync_q  <= 1'b0;
      mm_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mm_q <= mismatch;
          if (mm_q && mismatch) desync_q <= 1'b1;
          if (result_pop != '0 && status_pop != '0) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
            mm_q    <= 1'b0;
          end
        end
        POP: begin
          rd_en_q <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          res_q   <= result_data;
          sta_q   <= status_data;
          idx_q   <= '0;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (host.out_ready) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              records_q <= records_q + 16'd1;
              valid_q   <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // idx[1] selects result/status, idx[0] selects high/low half
  assign word           = idx_q[1] ? sta_q : res_q;
  assign half           = idx_q[0] ? word[width-1:0] : word[2*width-1:width];
  assign host.out_data  = valid_q ? half : '0;
  assign host.out_tag   = valid_q ? idx_q : 2'd0;
  assign host.out_last  = valid_q && idx_q == 2'd3;
  assign host.out_valid = valid_q;
  assign rd_en_result   = rd_en_q;
  assign rd_en_status   = rd_en_q;
  assign records_sent   = records_q;
  assign desync         = desync_q;
endmodule

// File: doc/pea_output_reader.md
# pea_output_reader

Drains the PEA result and status output FIFOs, the 32-bit FIFOs written together by the PEA top module's `wr_out`. It pops one result/status pair at a time and serialises each pair onto a 16-bit host stream with a valid/ready handshake. It sits between the two output FIFOs and the host/test harness, and replaces manual `rd_en_result`/`rd_en_status` pulsing.

## Interface
- `buffer_size_out`, 32: depth of each output FIFO; sets the pop-count width `log2(buffer_size_out)`.
- `width`, 16: host word width; FIFO words are `2*width`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `result_pop`  in  log2(buffer_size_out)  population of the result FIFO.
- `status_pop`  in  log2(buffer_size_out)  population of the status FIFO.
- `result_data`  in  2*width  result FIFO read data.
- `status_data`  in  2*width  status FIFO read data.
- `rd_en_result`  out  1  result FIFO pop strobe.
- `rd_en_status`  out  1  status FIFO pop strobe.
- `out_data`  out  width  host word.
- `out_tag`  out  2  word identity: 0 = result[31:16], 1 = result[15:0], 2 = status[31:16], 3 = status[15:0].
- `out_valid`  out  1  `out_data`/`out_tag` valid.
- `out_ready`  in  1  host accepts the word.
- `out_last`  out  1  high with tag 3, the final word of a record.
- `records_sent`  out  16  count of fully transferred records.
- `desync`  out  1  sticky: the FIFO populations disagreed.

## Operation
- FSM states: IDLE, POP, CAPTURE, SEND.
- IDLE → POP when `result_pop != 0` and `status_pop != 0`; otherwise stay in IDLE.
- POP, one cycle: `rd_en_result = rd_en_status = 1`, both driven as Moore outputs. The strobes are never asserted in any other state. Next state is CAPTURE.
- CAPTURE, one cycle: the FIFOs present the popped words this cycle. At the closing edge, load `result_data` and `status_data` into 32-bit holding registers and clear the word index to 0. Next state is SEND.
- SEND:
  - `out_valid = 1`; `out_tag` = word index; `out_data` = the selected half of the held word.
  - Each edge with `out_valid & out_ready` increments the index.
  - Handshake on index 3: increment `records_sent` (wraps 0xFFFF → 0x0000) and return to IDLE.
  - `out_data`/`out_tag` hold stable while `out_valid & ~out_ready`.
- Order is fixed: result high, result low, status high, status low.
- When `out_valid = 0`: `out_data = 0`, `out_tag = 0`, `out_last = 0`.
- Pairs are popped only when both FIFOs are non-empty. A lone non-empty FIFO is never popped.
- `desync`: a 1-bit flag remembers that IDLE saw `result_pop != status_pop` last cycle. `desync` sets when the mismatch holds on two consecutive IDLE cycles (the write side updates both FIFOs on the same edge, so a persistent mismatch is a fault). It clears only on reset.
- Holding registers are only overwritten in CAPTURE. No new pop occurs while a record is in SEND.

## Timing
- Reset: all outputs 0, holding registers 0, index 0, `records_sent` 0, `desync` 0, state IDLE. This applies whenever `rst` falls, including mid-record.
- A record in flight at reset is discarded; it was already popped and is not re-read.
- Latency, counting from the IDLE cycle in which both pops are non-zero (cycle 0):
  - POP (strobes high) in cycle 1.
  - CAPTURE in cycle 2.
  - `out_valid` first high in cycle 3.
- With `out_ready` held high, a record occupies cycles 1–6 and returns to IDLE in cycle 7. Back-to-back records start at 7-cycle spacing.
- Stall: `out_valid` remains high indefinitely while `out_ready = 0`, and no FIFO pop occurs.
- `out_ready` high while `out_valid` is low has no effect.
- Pop counts are sampled only in IDLE. Population changes during POP/CAPTURE/SEND are ignored.
- `records_sent` updates on the edge of the index-3 handshake and is visible the following cycle.

## Test plan
- **Single record.**
  - Stimulus: write result 0x12345678 and status 0x00000001 into the FIFOs; `out_ready = 1`.
  - Required: strobes high for exactly one cycle; host words 0x1234/0, 0x5678/1, 0x0000/2, 0x0001/3 with `out_last` on the fourth; `records_sent = 1`.
- **Back-pressure.**
  - Stimulus: same record; `out_ready = 0` for 5 cycles after `out_valid` rises.
  - Required: word 0x1234 with tag 0 held for 6 cycles; no second pop; the sequence then completes unchanged.
- **Three queued records.**
  - Stimulus: results 0xA, 0xB, 0xC with matching statuses; `out_ready` always 1.
  - Required: emitted in FIFO order; 7-cycle record spacing; `records_sent = 3`; both pops reach 0.
- **Desync.**
  - Stimulus: write only the result FIFO, then idle 3 cycles.
  - Required: no strobes; `desync = 1` from the second mismatched IDLE cycle onward, and it stays 1 after the status is written and the pair drains.
- **Reset mid-record.**
  - Stimulus: drop `rst` during SEND at index 2.
  - Required: all outputs 0 immediately; after release, the FSM sits in IDLE; the next queued record is emitted fresh from tag 0; `records_sent` restarts at 0.
- **Counter wrap.**
  - Stimulus: force `records_sent` to 0xFFFF, then send one record.
  - Required: `records_sent = 0x0000`.
